// File: rtl/pp_pkg.sv
// Shared definitions for the post-processing display path: pixel format,
// display-mode encoding, default frame geometry and small sizing helpers.
package pp_pkg;

    localparam logic MODE_COLOR = 1'b0;
    localparam logic MODE_GREY  = 1'b1;

    localparam int PIX_W       = 12;
    localparam int DEF_FRAME_W = 640;
    localparam int DEF_FRAME_H = 480;

    // One buffered entry: the pixel plus the frame-position flags that travel with it.
    typedef struct packed {
        logic [PIX_W-1:0] data;
        logic             sof;
        logic             eol;
    } pix_t;

    localparam int PIX_ENTRY_W = $bits(pix_t);

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ps_grey_expand_if.sv
// Stream bundle for ps_grey_expand: upstream pixel input, downstream RGB444
// output with frame flags. The block itself uses the slave side.
interface ps_grey_expand_if;
    import pp_pkg::*;

    logic             i_valid;
    logic [PIX_W-1:0] i_data;
    logic             o_ready;
    logic             o_valid;
    logic [PIX_W-1:0] o_data;
    logic             o_sof;
    logic             o_eol;
    logic             i_ready;

    modport slave (
        input  i_valid,
        input  i_data,
        input  i_ready,
        output o_ready,
        output o_valid,
        output o_data,
        output o_sof,
        output o_eol
    );

    modport master (
        output i_valid,
        output i_data,
        output i_ready,
        input  o_ready,
        input  o_valid,
        input  o_data,
        input  o_sof,
        input  o_eol
    );

endinterface

// File: rtl/ps_skid_buffer.sv
// Two-entry FIFO skid buffer with a registered input ready. The head entry is
// kept in a fixed register so the output holds its last value once drained.
module ps_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    logic [1:0]       cnt_q,  cnt_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic             ready_q, ready_d;
    logic             push, pop;

    always_comb begin
        push   = in_valid && ready_q;
        pop    = (cnt_q != 2'd0) && out_ready;
        cnt_d  = cnt_q;
        head_d = head_q;
        tail_d = tail_q;

        case (cnt_q)
            2'd0: begin
                if (push) begin
                    head_d = in_data;
                    cnt_d  = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_d = in_data;
                end else if (push) begin
                    tail_d = in_data;
                    cnt_d  = 2'd2;
                end else if (pop) begin
                    cnt_d  = 2'd0;
                end
            end
            default: begin
                // Full: ready was low, so only a pop can happen here.
                if (pop) begin
                    head_d = tail_q;
                    cnt_d  = 2'd1;
                end
            end
        endcase

        ready_d = (cnt_d < 2'd2);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cnt_q   <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            ready_q <= ready_d;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = head_q;

endmodule

// File: rtl/ps_grey_expand.sv
// Converts the 8-bit luma stream back to RGB444 (or passes colour through),
// tags each pixel with start-of-frame / end-of-line and buffers it for display.
module ps_grey_expand
    import pp_pkg::*;
#(
    parameter int FRAME_W = DEF_FRAME_W,
    parameter int FRAME_H = DEF_FRAME_H
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_mode,
    ps_grey_expand_if.slave    bus
);

    localparam int XW = cnt_w(FRAME_W);
    localparam int YW = cnt_w(FRAME_H);
    localparam logic [XW-1:0] X_LAST = XW'(FRAME_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(FRAME_H - 1);

    // Rounded upper nibble of the luma: Y[7:4] + Y[3], clamped to 4'hF.
    function automatic logic [3:0] grey_nibble(input logic [7:0] luma);
        logic [4:0] sum;
        sum = {1'b0, luma[7:4]} + {4'b0000, luma[3]};
        return sum[4] ? 4'hF : sum[3:0];
    endfunction

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          mode_q, mode_d;

    logic          accept;
    logic          at_origin;
    logic          x_last;
    logic          mode_cur;
    logic [3:0]    nib;
    pix_t          pix_in;
    pix_t          pix_out;
    logic          buf_ready;

    always_comb begin
        accept    = bus.i_valid && buf_ready;
        at_origin = (x_q == '0) && (y_q == '0);
        x_last    = (x_q == X_LAST);
        // The pixel at (0,0) uses the freshly sampled mode, not the stale latch.
        mode_cur  = at_origin ? i_mode : mode_q;

        x_d    = x_q;
        y_d    = y_q;
        mode_d = mode_q;
        if (accept) begin
            if (at_origin) begin
                mode_d = i_mode;
            end
            if (x_last) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end

        nib         = grey_nibble(bus.i_data[11:4]);
        pix_in.data = (mode_cur == MODE_GREY) ? {nib, nib, nib} : bus.i_data;
        pix_in.sof  = at_origin;
        pix_in.eol  = x_last;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            x_q    <= '0;
            y_q    <= '0;
            mode_q <= MODE_COLOR;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            mode_q <= mode_d;
        end
    end

    ps_skid_buffer #(
        .WIDTH (PIX_ENTRY_W)
    ) u_skid (
        .i_clk     (i_clk),
        .i_rstn    (i_rstn),
        .in_valid  (bus.i_valid),
        .in_data   (pix_in),
        .in_ready  (buf_ready),
        .out_valid (bus.o_valid),
        .out_data  (pix_out),
        .out_ready (bus.i_ready)
    );

    assign bus.o_ready = buf_ready;
    assign bus.o_data  = pix_out.data;
    assign bus.o_sof   = pix_out.sof;
    assign bus.o_eol   = pix_out.eol;

endmodule

// File: tb/tb_ps_grey_expand.sv
// Directed bench for ps_grey_expand on a 4x2 frame: streaming vector table
// followed by hand-written stall and mid-frame reset sequences.
module tb_ps_grey_expand;
    import pp_pkg::*;

    typedef struct {
        logic        mode;
        logic [11:0] din;
        logic [11:0] dout;
        logic        sof;
        logic        eol;
    } vec_t;

    localparam int NVEC = 18;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic mode = 1'b0;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs [NVEC];

    always #5 clk = ~clk;

    ps_grey_expand_if bus();

    ps_grey_expand #(
        .FRAME_W (4),
        .FRAME_H (2)
    ) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .i_mode (mode),
        .bus    (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pix(input string name, input logic [11:0] d, input logic s, input logic e);
        chk({name, ".valid"}, 32'(bus.o_valid), 32'd1);
        chk({name, ".data"},  32'(bus.o_data),  32'(d));
        chk({name, ".sof"},   32'(bus.o_sof),   32'(s));
        chk({name, ".eol"},   32'(bus.o_eol),   32'(e));
    endtask

    initial begin
        // Frame A: grey latched at (0,0); mode toggles later are ignored.
        vecs[0]  = '{1'b1, 12'h7F0, 12'h888, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 12'hFF0, 12'hFFF, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 12'h070, 12'h000, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 12'h123, 12'h111, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 12'h08A, 12'h111, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 12'hF80, 12'hFFF, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 12'h3C5, 12'h444, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 12'h000, 12'h000, 1'b0, 1'b1};
        // Frame B: colour latched; i_mode goes to 1 at pixel 2.
        vecs[8]  = '{1'b0, 12'hA5C, 12'hA5C, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 12'h123, 12'h123, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 12'hA5C, 12'hA5C, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 12'hFF0, 12'hFF0, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 12'h456, 12'h456, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 12'h789, 12'h789, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 12'hABC, 12'hABC, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 12'hDEF, 12'hDEF, 1'b0, 1'b1};
        // Frame C: grey picked up at the new (0,0).
        vecs[16] = '{1'b1, 12'h7F0, 12'h888, 1'b1, 1'b0};
        vecs[17] = '{1'b1, 12'h550, 12'h555, 1'b0, 1'b0};

        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        bus.i_ready = 1'b1;

        // Reset state
        step();
        step();
        chk("rst.o_valid", 32'(bus.o_valid), 32'd0);
        chk("rst.o_data",  32'(bus.o_data),  32'd0);
        chk("rst.o_sof",   32'(bus.o_sof),   32'd0);
        chk("rst.o_eol",   32'(bus.o_eol),   32'd0);
        chk("rst.o_ready", 32'(bus.o_ready), 32'd0);
        rstn = 1'b1;
        step();
        chk("rel.o_ready", 32'(bus.o_ready), 32'd1);
        chk("rel.o_valid", 32'(bus.o_valid), 32'd0);

        // Streaming table, i_ready held high: each pixel appears one edge later.
        for (int i = 0; i < NVEC; i++) begin
            bus.i_valid = 1'b1;
            bus.i_data  = vecs[i].din;
            mode        = vecs[i].mode;
            step();
            chk_pix($sformatf("vec%0d", i), vecs[i].dout, vecs[i].sof, vecs[i].eol);
            chk($sformatf("vec%0d.ready", i), 32'(bus.o_ready), 32'd1);
        end
        bus.i_valid = 1'b0;
        step();
        chk("drain.o_valid", 32'(bus.o_valid), 32'd0);
        chk("drain.hold",    32'(bus.o_data),  32'h555);

        // Stall: three pushes with i_ready low (frame C, x=2,3 then (0,1)).
        bus.i_ready = 1'b0;
        bus.i_valid = 1'b1;
        bus.i_data  = 12'h200;
        step();
        chk("stall1.ready", 32'(bus.o_ready), 32'd1);
        chk_pix("stall1", 12'h222, 1'b0, 1'b0);
        bus.i_data = 12'h400;
        step();
        chk("stall2.ready", 32'(bus.o_ready), 32'd0);
        chk_pix("stall2", 12'h222, 1'b0, 1'b0);
        bus.i_data = 12'h600;
        step();
        chk("stall3.ready", 32'(bus.o_ready), 32'd0);
        chk_pix("stall3", 12'h222, 1'b0, 1'b0);
        step();
        chk("stall4.ready", 32'(bus.o_ready), 32'd0);
        chk_pix("stall4", 12'h222, 1'b0, 1'b0);
        bus.i_ready = 1'b1;
        step();
        chk("rel1.ready", 32'(bus.o_ready), 32'd1);
        chk_pix("rel1", 12'h444, 1'b0, 1'b1);
        step();
        chk_pix("rel2", 12'h666, 1'b0, 1'b0);
        bus.i_valid = 1'b0;
        step();
        chk("rel3.o_valid", 32'(bus.o_valid), 32'd0);
        chk("rel3.hold",    32'(bus.o_data),  32'h666);

        // Mid-line reset with two entries buffered (frame C at x=1,y=1).
        bus.i_ready = 1'b0;
        bus.i_valid = 1'b1;
        bus.i_data  = 12'h100;
        step();
        bus.i_data = 12'h300;
        step();
        chk("full.ready", 32'(bus.o_ready), 32'd0);
        chk_pix("full", 12'h111, 1'b0, 1'b0);
        bus.i_valid = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        chk("arst.o_valid", 32'(bus.o_valid), 32'd0);
        chk("arst.o_data",  32'(bus.o_data),  32'd0);
        chk("arst.o_sof",   32'(bus.o_sof),   32'd0);
        chk("arst.o_eol",   32'(bus.o_eol),   32'd0);
        chk("arst.o_ready", 32'(bus.o_ready), 32'd0);
        step();
        rstn = 1'b1;
        step();
        chk("arel.ready", 32'(bus.o_ready), 32'd1);
        chk("arel.o_valid", 32'(bus.o_valid), 32'd0);
        bus.i_ready = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_data  = 12'hA5C;
        mode        = 1'b0;
        step();
        chk_pix("post_rst", 12'hA5C, 1'b1, 1'b0);
        bus.i_valid = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps_grey_expand.md
# ps_grey_expand

Post-processing stage that converts the 8-bit luma stream produced by the greyscale pre-processor back into RGB444 for the display path. It sits after the processing pipeline and before the display FIFO. It adds a valid/ready handshake with a 2-entry skid buffer, frame-position tracking (start-of-frame and end-of-line flags), and a display-mode select that is latched only at frame boundaries.

## Interface
- FRAME_W, 640, active pixels per line
- FRAME_H, 480, active lines per frame
- i_clk  in  1  system clock; all logic on the rising edge
- i_rstn  in  1  asynchronous, active-low reset
- i_mode  in  1  0 = colour passthrough, 1 = greyscale expand; sampled only at frame start
- i_valid  in  1  upstream pixel valid
- i_data  in  12  in grey mode: luma in [11:4], [3:0] ignored; in colour mode: RGB444 {R[11:8],G[7:4],B[3:0]}
- o_ready  out  1  may accept input; registered
- o_valid  out  1  output pixel valid
- o_data  out  12  RGB444 pixel
- o_sof  out  1  high with the pixel at (x=0, y=0)
- o_eol  out  1  high with the pixel at x=FRAME_W-1
- i_ready  in  1  downstream ready

## Operation
- A transfer occurs on an edge where valid && ready on that interface. Input is accepted iff i_valid && o_ready.
- Counters x (0..FRAME_W-1) and y (0..FRAME_H-1) advance on every accepted input.
  - x wraps to 0 after FRAME_W-1, and y then increments.
  - y wraps to 0 after FRAME_H-1.
- Mode latch: the active mode is loaded from i_mode on an accepted pixel at (0,0) and applies to that pixel. It holds for the whole frame; i_mode changes mid-frame are ignored.
- Grey expand with Y = i_data[11:4]:
  - n = Y[7:4] + Y[3], saturated to 15.
  - o_data = {n,n,n}.
  - Arithmetic is 5 bits wide before saturation.
- Colour passthrough: o_data = i_data unchanged.
- sof/eol flags are computed from the (x,y) of the accepted pixel and travel with it through the buffer.
- Skid buffer holds 2 entries of {data[11:0], sof, eol}.
  - o_ready = 1 when occupancy < 2, registered from next-state occupancy.
  - Head entry drives o_data/o_sof/o_eol. o_valid = occupancy != 0.
  - Output data is stable while o_valid && !i_ready.
- Simultaneous push and pop: occupancy unchanged, order preserved (FIFO).
- Full (2 entries): o_ready = 0, and no input is lost.
- Empty: o_valid = 0, and o_data/o_sof/o_eol hold their last value.

## Timing
- Latency: 1 cycle from input transfer to o_valid when the buffer is empty.
- Throughput: 1 pixel/cycle sustained while i_ready = 1.
- Reset (asynchronous assert, synchronous-to-clock release):
  - o_valid, o_data, o_sof, o_eol = 0.
  - o_ready = 0 during reset, 1 on the first edge after release.
  - x = y = 0, active mode = 0, buffer empty.
- Reset mid-frame: all of the above, and buffered pixels are discarded. The next accepted pixel is treated as (0,0) and resamples i_mode.
- o_ready deasserts on the edge where occupancy reaches 2. It reasserts on the edge after a pop with no push.

## Structure
- Shared package pp_pkg holds:
  - MODE_COLOR = 1'b0, MODE_GREY = 1'b1
  - PIX_W = 12 (RGB444 pixel width)
  - default frame dimensions
- Sub-module ps_skid_buffer (2-entry, WIDTH parameter, valid/ready on both sides) holds all buffering.
- The top level contains the counters, mode latch, expand/round logic and flag generation.

## Test plan
- Grey mode, i_data = 12'h7F0 (Y=0x7F) -> o_data = 12'h888. 12'hFF0 -> 12'hFFF (saturation). 12'h070 -> 12'h000.
- Colour mode, stream 12'hA5C, 12'h123 with i_ready=1 -> same values out 1 cycle later, o_sof high on the first pixel.
- Full frame at FRAME_W=4, FRAME_H=2 -> o_eol on pixels 3 and 7, o_sof only on pixels 0 and 8. The counter wraps correctly.
- Hold i_ready=0 while pushing 3 pixels -> o_ready low after 2 accepts, and the 3rd waits. Release i_ready -> all 3 emerge in order, none lost or duplicated.
- Toggle i_mode 0→1 at pixel 2 of a frame -> that frame stays passthrough, and the next frame's (0,0) pixel is expanded.
- Assert i_rstn low with 2 pixels buffered mid-line -> outputs 0 immediately (asynchronous). After release, the next pixel carries o_sof=1.
